// File: rtl/cache_types.sv
// cache_types: shared geometry, FSM state encoding and line helpers for l1_cache.
package cache_types;
  localparam int S_INDEX = 3;
  localparam int S_OFFSET = 5;
  localparam int S_TAG = 32 - S_INDEX - S_OFFSET;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;
  typedef logic [S_TAG-1:0] tag_t;
  typedef logic [255:0] line_t;
  // Overlay the enabled byte lanes of wdata onto one word of a line.
  function automatic line_t merge_word(line_t line, logic [2:0] word, logic [3:0] be, logic [31:0] wdata);
    line_t r;
    r = line;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[{word, 2'(i), 3'b000} +: 8] = wdata[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/cache_control.sv
// cache_control: miss-handling FSM sequencing writeback and fill for l1_cache.
module cache_control
  import cache_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic hit,
  input  logic dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_line,
  output logic clr_dirty,
  output logic addr_sel
);
  state_t state;
  assign mem_resp = state == IDLE && req && hit;
  // A response landing in a reset cycle belongs to an abandoned transaction.
  assign load_line = state == FETCH && pmem_resp && !reset;
  assign clr_dirty = state == WRITEBACK && pmem_resp && !reset;
  assign addr_sel = state == WRITEBACK;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req && !hit) begin
          state <= dirty ? WRITEBACK : FETCH;
          pmem_write <= dirty;
          pmem_read <= !dirty;
        end
        WRITEBACK: if (pmem_resp) begin
          state <= FETCH;
          pmem_write <= 1'b0;
          pmem_read <= 1'b1;
        end
        FETCH: if (pmem_resp) begin
          state <= IDLE;
          pmem_read <= 1'b0;
        end
        default: begin
          state <= IDLE;
          pmem_read <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/l1_cache.sv
// l1_cache: direct-mapped write-back write-allocate cache with flop-based tag/data arrays.
module l1_cache
  import cache_types::*;
#(
  parameter int S_INDEX = cache_types::S_INDEX,
  parameter int S_OFFSET = cache_types::S_OFFSET,
  parameter int S_TAG = 32 - S_INDEX - S_OFFSET
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata
);
  localparam int SETS = 2 ** S_INDEX;
  logic [S_TAG-1:0] tag_a [SETS];
  line_t data_a [SETS];
  logic [SETS-1:0] valid, dirty;
  logic [S_TAG-1:0] addr_tag;
  logic [S_INDEX-1:0] idx;
  logic [S_OFFSET-3:0] word;
  logic hit, wr_hit, load_line, clr_dirty, addr_sel;
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_address[1:0]};
  assign addr_tag = mem_address[31 -: S_TAG];
  assign idx = mem_address[S_OFFSET +: S_INDEX];
  assign word = mem_address[S_OFFSET-1:2];
  assign hit = valid[idx] && tag_a[idx] == addr_tag;
  assign wr_hit = mem_resp && mem_write;
  assign mem_rdata = data_a[idx][{word, 5'b00000} +: 32];
  assign pmem_address = addr_sel ? {tag_a[idx], idx, {S_OFFSET{1'b0}}}
                      : pmem_read ? {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}} : '0;
  assign pmem_wdata = pmem_write ? data_a[idx] : '0;
  cache_control ctrl (
    .clk(clk),
    .reset(reset),
    .req(mem_read || mem_write),
    .hit(hit),
    .dirty(dirty[idx]),
    .pmem_resp(pmem_resp),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .load_line(load_line),
    .clr_dirty(clr_dirty),
    .addr_sel(addr_sel)
  );
  always_ff @(posedge clk) begin
    if (load_line) begin
      data_a[idx] <= pmem_rdata;
      tag_a[idx] <= addr_tag;
    end else if (wr_hit) begin
      data_a[idx] <= merge_word(data_a[idx], word, mem_byte_enable, mem_wdata);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (load_line) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (clr_dirty) dirty[idx] <= 1'b0;
      if (wr_hit) dirty[idx] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: directed scoreboard bench with a fixed-latency line memory model.
module tb_l1_cache;
  localparam int LAT = 3;
  localparam int BUDGET = 40;
  logic clk = 1'b0, reset = 1'b1, mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0] be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic mem_resp, pmem_read, pmem_write;
  logic pmem_resp = 1'b0;
  logic [31:0] mem_rdata, pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  typedef struct {bit rd; logic [31:0] data;} resp_t;
  typedef struct {bit wr; logic [31:0] addr; logic [31:0] w0;} ptx_t;
  resp_t sb[$];
  ptx_t pq[$];
  logic [255:0] mem [logic [31:0]];
  int total = 0, bad = 0, pcnt = 0;

  l1_cache dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pmem(bit wr, logic [31:0] a, logic [31:0] w0);
    ptx_t p;
    p.wr = wr; p.addr = a; p.w0 = w0;
    pq.push_back(p);
  endtask

  task automatic access(string name, bit rd, bit wr, logic [31:0] a, logic [3:0] b,
                        logic [31:0] d, logic [31:0] exp, int exp_lat);
    resp_t e;
    int lat;
    e.rd = rd && !wr; e.data = exp;
    sb.push_back(e);
    lat = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; be = b; wdata = d;
    @(negedge clk);
    while (!mem_resp && lat < BUDGET) begin
      lat++;
      @(negedge clk);
    end
    if (!mem_resp) begin
      total++; bad++;
      $display("FAIL %s: no mem_resp within %0d cycles", name, BUDGET);
    end else begin
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      if (exp_lat == 0) chk({name, "_pmem_idle"}, {30'b0, pmem_read, pmem_write}, 32'd0);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (pmem_read || pmem_write) chk("pmem_excl", 32'(pmem_read & pmem_write), 32'd0);
    if (!reset && mem_resp) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got mem_resp at %h expected none", addr);
      end else begin
        e = sb.pop_front();
        if (e.rd) chk("rdata", mem_rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    ptx_t p;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      pcnt = 0;
    end else if (pmem_read || pmem_write) begin
      pcnt++;
      if (pcnt == LAT) begin
        if (pq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pmem: got access at %h expected none", pmem_address);
        end else begin
          p = pq.pop_front();
          chk("pmem_wr", 32'(pmem_write), 32'(p.wr));
          chk("pmem_addr", pmem_address, p.addr);
          if (p.wr) chk("pmem_wdata0", pmem_wdata[31:0], p.w0);
        end
        if (pmem_write) mem[pmem_address] = pmem_wdata;
        else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : '0;
        pmem_resp = 1'b1;
      end
    end else begin
      pcnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h40] = {192'h0, 32'h1111_2222, 32'hDEAD_BEEF};
    mem[32'h1040] = {224'h0, 32'hCAFE_F00D};
    mem[32'h80] = {224'h0, 32'h0BAD_0080};
    mem[32'h2080] = {160'h0, 32'h7777_7777, 64'h0};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_resp", 32'(mem_resp), 32'd0);
    chk("reset_pread", 32'(pmem_read), 32'd0);
    chk("reset_pwrite", 32'(pmem_write), 32'd0);
    expect_pmem(1'b0, 32'h40, 32'h0);
    access("cold_read", 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 32'hDEAD_BEEF, LAT + 1);
    access("hit_read", 1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 32'h1111_2222, 0);
    access("part_write", 1'b0, 1'b1, 32'h40, 4'b0101, 32'hAABB_CCDD, 32'h0, 0);
    access("merged_read", 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 32'hDEBB_BEDD, 0);
    chk("dirty2", 32'(dut.dirty[2]), 32'd1);
    expect_pmem(1'b1, 32'h40, 32'hDEBB_BEDD);
    expect_pmem(1'b0, 32'h1040, 32'h0);
    access("evict_read", 1'b1, 1'b0, 32'h1040, 4'h0, 32'h0, 32'hCAFE_F00D, 2 * LAT + 2);
    chk("wb_mem_word1", mem[32'h40][63:32], 32'h1111_2222);
    access("rw_write", 1'b1, 1'b1, 32'h1040, 4'hF, 32'h1234_5678, 32'h0, 0);
    access("rw_read", 1'b1, 1'b0, 32'h1040, 4'h0, 32'h0, 32'h1234_5678, 0);
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    chk("rst_fetch_pread", 32'(pmem_read), 32'd1);
    chk("rst_fetch_addr", pmem_address, 32'h80);
    reset = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    chk("rst_pread_drop", 32'(pmem_read), 32'd0);
    chk("rst_invalid", 32'(dut.valid), 32'd0);
    reset = 1'b0;
    expect_pmem(1'b0, 32'h80, 32'h0);
    access("refetch_read", 1'b1, 1'b0, 32'h80, 4'h0, 32'h0, 32'h0BAD_0080, LAT + 1);
    expect_pmem(1'b0, 32'h2080, 32'h0);
    access("wmiss_write", 1'b0, 1'b1, 32'h2088, 4'b1100, 32'hABCD_0000, 32'h0, LAT + 1);
    access("wmiss_read", 1'b1, 1'b0, 32'h2088, 4'h0, 32'h0, 32'hABCD_7777, 0);
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("pq_empty", 32'(pq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
